// File: rtl/led_pkg.sv
// Shared constants for the LED pattern engine.
// Mode encodings and direction values used by the top and the bench.
package led_pkg;

    localparam logic [1:0] MODE_RUN    = 2'b00;
    localparam logic [1:0] MODE_ROT    = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_BAR    = 2'b11;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/led_pattern_engine_tick_gen.sv
// Step prescaler: counts 0..DIV-1 while enabled.
// The tick is the cycle the count sits on DIV-1.
module tick_gen #(
    parameter int DIV   = 50000000,
    parameter int CNT_W = $clog2(DIV)
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic restart,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (restart || tick) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_pattern_engine.sv
// Four-mode LED pattern generator driven by a prescaled step tick.
// q is registered from the next-state image, so it moves with the state.
module led_pattern_engine
    import led_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV   = 50000000,
    parameter int CNT_W = $clog2(DIV),
    parameter int POS_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] q,
    output logic             step_tick
);

    localparam logic [POS_W-1:0] LAST = POS_W'(WIDTH - 1);
    localparam logic [POS_W-1:0] FULL = POS_W'(WIDTH);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [POS_W-1:0] pos, pos_n;
    logic [POS_W-1:0] level, level_n;
    logic             bdir, bdir_n;
    logic [WIDTH-1:0] pattern, pattern_n;
    logic [1:0]       mode_q, mode_n;
    logic [WIDTH-1:0] q_n;
    logic             tick;
    logic             restart;

    tick_gen #(
        .DIV   (DIV),
        .CNT_W (CNT_W)
    ) u_tick (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .restart (restart),
        .tick    (tick)
    );

    assign step_tick = tick;

    function automatic logic [WIDTH-1:0] image(
        input logic [1:0]       m,
        input logic [POS_W-1:0] p,
        input logic [POS_W-1:0] l,
        input logic [WIDTH-1:0] pat
    );
        logic [WIDTH-1:0] img;
        img = '0;
        unique case (m)
            MODE_ROT: img = pat;
            MODE_BAR: begin
                for (int i = 0; i < WIDTH; i++)
                    img[i] = (POS_W'(i) < l);
            end
            default: begin
                for (int i = 0; i < WIDTH; i++)
                    img[i] = (p == POS_W'(i));
            end
        endcase
        return img;
    endfunction

    always_comb begin
        restart   = 1'b0;
        pos_n     = pos;
        level_n   = level;
        bdir_n    = bdir;
        pattern_n = pattern;
        mode_n    = mode_q;
        if (clr) begin
            restart   = 1'b1;
            pos_n     = '0;
            level_n   = '0;
            bdir_n    = DIR_UP;
            pattern_n = ONE;
            mode_n    = MODE_RUN;
        end else if (mode != mode_q) begin
            restart = 1'b1;
            mode_n  = mode;
            pos_n   = '0;
            level_n = '0;
            bdir_n  = DIR_UP;
        end else if (load) begin
            pattern_n = load_data;
        end else if (tick) begin
            unique case (mode_q)
                MODE_RUN: begin
                    if (dir == DIR_UP)
                        pos_n = (pos == LAST) ? '0 : pos + 1'b1;
                    else
                        pos_n = (pos == '0) ? LAST : pos - 1'b1;
                end
                MODE_ROT: begin
                    if (dir == DIR_UP)
                        pattern_n = {pattern[WIDTH-2:0], pattern[WIDTH-1]};
                    else
                        pattern_n = {pattern[0], pattern[WIDTH-1:1]};
                end
                MODE_BOUNCE: begin
                    // Ends reflect immediately so each end is lit one step.
                    if (bdir == DIR_UP) begin
                        if (pos == LAST) begin
                            pos_n  = LAST - 1'b1;
                            bdir_n = DIR_DN;
                        end else begin
                            pos_n = pos + 1'b1;
                        end
                    end else begin
                        if (pos == '0) begin
                            pos_n  = POS_W'(1);
                            bdir_n = DIR_UP;
                        end else begin
                            pos_n = pos - 1'b1;
                        end
                    end
                end
                default: begin
                    if (dir == DIR_UP)
                        level_n = (level == FULL) ? '0 : level + 1'b1;
                    else
                        level_n = (level == '0) ? FULL : level - 1'b1;
                end
            endcase
        end
        q_n = image(mode_n, pos_n, level_n, pattern_n);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos     <= '0;
            level   <= '0;
            bdir    <= DIR_UP;
            pattern <= ONE;
            mode_q  <= MODE_RUN;
            q       <= ONE;
        end else begin
            pos     <= pos_n;
            level   <= level_n;
            bdir    <= bdir_n;
            pattern <= pattern_n;
            mode_q  <= mode_n;
            q       <= q_n;
        end
    end

endmodule
